ok_upstream_blocker: RTL and testbench
======================================

# ok_upstream_blocker

Parametrised upstream staging block between NCH PC upstream Channels and the Opal Kelly block-throttled pipe-out endpoint (address 0xA0). It round-robin merges upstream words into a FIFO, presents whole BLOCK_WORDS blocks to the host, and closes stale partial blocks by padding with NOP words. It supersedes the single-channel upstream path inside the OK interface.

## Interface
- NCH, 2: number of upstream Channels merged (1..8).
- NPC, 32: word width; must equal the pipe width.
- BLOCK_WORDS, 512: words per host block; power of 2.
- DEPTH, 2048: FIFO depth in words; power of 2, at least 2*BLOCK_WORDS.
- TIMEOUT, 1024: idle cycles before a partial block is padded; at least 2.
- clk  in  1  okClk domain; the only clock.
- reset  in  1  synchronous, active-low.
- up_v  in  NCH  per-channel valid.
- up_d  in  NCH*NPC  per-channel data; channel k occupies bits [k*NPC +: NPC].
- up_a  out  NCH  per-channel accept (combinational, one-hot or zero).
- ep_read  in  1  BTPipeOut read strobe.
- ep_ready  out  1  at least one complete block is available.
- ep_datain  out  NPC  pipe-out data.
- blocks_avail  out  log2(DEPTH/BLOCK_WORDS)+1  complete, unstarted blocks.
- pad_active  out  1  pad state is active.
- err_underflow  out  1  sticky; set on a read of an empty FIFO.

## Operation
- **Transfer rule:** a word transfers on a cycle with up_v[k] && up_a[k].
- **Arbitration:** grant the first valid channel at or after rr_ptr, subject to the grant conditions below.
  - Grant requires state RUN and FIFO count < DEPTH.
  - After a transfer, rr_ptr = (granted+1) mod NCH.
  - At most one word is written per cycle.
- **Block accounting:**
  - fill = low log2(BLOCK_WORDS) bits of the total-writes counter.
  - When a write wraps fill to 0, blocks_avail increments.
  - An ep_read with rd_in_block == 0 starts a block and decrements blocks_avail.
  - rd_in_block counts 0..BLOCK_WORDS-1 and wraps.
  - If a completion and a block start occur in the same cycle, blocks_avail is unchanged.
- **ep_ready:** registered; = (blocks_avail != 0).
  - A block once started is always fully present.
  - The host may assert ep_read while ep_ready is low only to finish a started block.
- **States:**
  - RUN: accept input.
  - PAD: up_a = 0. Write the NOP word (route 31, code 64, data 0) each cycle that count < DEPTH. Stall without writing when full. Return to RUN on the write that makes fill == 0.
- **Idle timer:** cleared when fill == 0 or a word is accepted; otherwise increments while fill != 0. When timer == TIMEOUT-1, RUN→PAD.
- **Underflow:** ep_read with count == 0 performs no pop, drives ep_datain = 0 next cycle, and sets err_underflow. Only reset clears it.
- **Reset values:** up_a=0, ep_ready=0, ep_datain=0, blocks_avail=0, pad_active=0, err_underflow=0. Pointers, counters, timer and rr_ptr are 0; state is RUN.
- **Reset mid-block:** discards all FIFO contents and any partially read block. There is no recovery handshake; the host must re-sync.

## Timing
- up_a depends only on up_v and registered state, with no other input-to-output path.
- Write latency: a word accepted at cycle t counts toward count/fill at t+1.
- A block-completing write at t gives blocks_avail at t+1 and ep_ready at t+2.
- Read latency 1: ep_read at t gives the word on ep_datain at t+1, held until the next pop.
- Simultaneous write and pop leaves count unchanged. The FIFO is never written at full and never popped at empty.
- Timeout: last accepted word at t gives pad_active high at t+TIMEOUT and the first NOP written at t+TIMEOUT.

## Configuration
- PC_UP_TIMEOUT_FLUSH_EN defined: the idle timer and PAD state are compiled in.
- Undefined: no timer, and the state is always RUN. Partial blocks wait indefinitely for data. pad_active is tied to 0, and TIMEOUT is ignored.

## Structure
- Package pc_up_pkg holds:
  - the NOP word constants GO_HOME_rt=31, NOPcode=64, NPCdata=20;
  - the state enum {RUN, PAD};
  - the nop_word function returning the packed NPC-bit NOP.
- Sub-module pc_up_fifo: synchronous single-clock FIFO with read latency 1, count output, and full/empty flags. It is inferable as block RAM.

## Test plan
Bench parameters: NCH=2, BLOCK_WORDS=8, DEPTH=32, TIMEOUT=16.
- Both channels valid continuously with ch0 words 0x100+i and ch1 0x200+i → FIFO order alternates 0x100,0x200,0x101,… and ep_ready rises 2 cycles after the 8th write.
- 3 words then idle (macro defined) → pad_active high 16 cycles after the last accept; 5 NOPs (0xF8000000) written; ep_ready high; block reads back as 3 data + 5 NOPs.
- Same stimulus with the macro undefined → ep_ready stays 0 for 1000 cycles; 5 further words complete the block.
- Fill 32 words with the host idle → up_a stays 0 while full; blocks_avail=4; reading one block (8 ep_read) reopens up_a on the next cycle.
- ep_read with an empty FIFO → ep_datain=0, err_underflow=1 and held; no pointer movement.
- Reset low for 1 cycle at mid-block read (rd_in_block=4) → all outputs at reset values next cycle; a new 8-word stream reads back intact.

Source files
------------

// File: rtl/pc_up_pkg.sv
// pc_up_pkg: shared NOP word constants, staging state enum and NOP word builder.
package pc_up_pkg;
  localparam int GO_HOME_rt = 31;
  localparam int NOPcode = 64;
  localparam int NPCdata = 20;
  typedef enum logic {RUN, PAD} state_t;
  // The opcode field is 6 bits wide, so NOPcode aliases to 0 and the word is 0xF8000000.
  function automatic logic [31:0] nop_word();
    return {5'(GO_HOME_rt), 1'b0, 6'(NOPcode), {NPCdata{1'b0}}};
  endfunction
endpackage

// File: rtl/pc_up_fifo.sv
// pc_up_fifo: single-clock FIFO with registered read data, count and full/empty flags.
module pc_up_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 2048,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign wr = wr_en && !full;
  assign rd = rd_en && !empty;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wr_data;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      rd_data <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) begin
        rp <= rp + 1'b1;
        rd_data <= mem[rp];
      end
      count <= count + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/ok_upstream_blocker.sv
// ok_upstream_blocker: round-robin merge of upstream channels into block-granular pipe-out staging.
// Define PC_UP_TIMEOUT_FLUSH_EN to pad stale partial blocks with NOP words after TIMEOUT idle cycles.
module ok_upstream_blocker
  import pc_up_pkg::*;
#(
  parameter int NCH = 2,
  parameter int NPC = 32,
  parameter int BLOCK_WORDS = 512,
  parameter int DEPTH = 2048,
  parameter int TIMEOUT = 1024,
  parameter int BW = $clog2(DEPTH / BLOCK_WORDS) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   up_v,
  input  logic [NCH*NPC-1:0] up_d,
  output logic [NCH-1:0]   up_a,
  input  logic             ep_read,
  output logic             ep_ready,
  output logic [NPC-1:0]   ep_datain,
  output logic [BW-1:0]    blocks_avail,
  output logic             pad_active,
  output logic             err_underflow
);
  localparam int FW = $clog2(BLOCK_WORDS);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = NCH > 1 ? $clog2(NCH) : 1;
  if (TIMEOUT < 2 || DEPTH < 2 * BLOCK_WORDS) begin : g_bad_param
    $error("ok_upstream_blocker: TIMEOUT >= 2 and DEPTH >= 2*BLOCK_WORDS required");
  end
  state_t state;
  logic [PW-1:0] rr_ptr, gi, j;
  logic found, acc, wr_en, pop, full, empty, zero_q, inc, dec;
  logic [FW-1:0] fill, rd_in_block;
  logic [CW-1:0] cnt;
  logic [NPC-1:0] wr_data, q;
  always_comb begin
    found = 1'b0;
    gi = '0;
    j = '0;
    for (int i = 0; i < NCH; i++) begin
      j = PW'((int'(rr_ptr) + i) % NCH);
      if (!found && up_v[j]) begin
        found = 1'b1;
        gi = j;
      end
    end
  end
  assign up_a = (state == RUN && cnt < CW'(DEPTH) && found) ? NCH'(1) << gi : '0;
  assign acc = |up_a;
  assign wr_en = acc || (state == PAD && !full);
  assign wr_data = state == PAD ? NPC'(nop_word()) : up_d[gi*NPC +: NPC];
  assign pop = ep_read && !empty;
  assign inc = wr_en && fill == FW'(BLOCK_WORDS - 1);
  assign dec = pop && rd_in_block == '0;
  assign ep_datain = zero_q ? '0 : q;
  assign pad_active = state == PAD;
  pc_up_fifo #(.W(NPC), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(pop),
    .rd_data(q), .count(cnt), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
      fill <= '0;
      rd_in_block <= '0;
      blocks_avail <= '0;
      ep_ready <= 1'b0;
      zero_q <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (acc) rr_ptr <= gi == PW'(NCH - 1) ? '0 : gi + 1'b1;
      if (wr_en) fill <= fill + 1'b1;
      if (pop) rd_in_block <= rd_in_block + 1'b1;
      blocks_avail <= blocks_avail + BW'(inc) - BW'(dec);
      ep_ready <= blocks_avail != '0;
      if (ep_read) zero_q <= empty;
      if (ep_read && empty) err_underflow <= 1'b1;
    end
  end
`ifdef PC_UP_TIMEOUT_FLUSH_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] timer;
  // Switch on the edge where timer reaches TIMEOUT-1 so PAD and the first NOP land TIMEOUT cycles after the last accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
      timer <= '0;
    end else begin
      timer <= (fill == '0 || acc || state == PAD) ? '0 : timer + 1'b1;
      if (state == RUN && !acc && fill != '0 && timer == TW'(TIMEOUT - 2)) state <= PAD;
      else if (state == PAD && inc) state <= RUN;
    end
  end
`else
  assign state = RUN;
`endif
endmodule

// File: tb/tb_ok_upstream_blocker.sv
// tb_ok_upstream_blocker: directed bench for ok_upstream_blocker with NCH=2, BLOCK_WORDS=8, DEPTH=32, TIMEOUT=16.
module tb_ok_upstream_blocker;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] up_v;
  logic [63:0] up_d;
  logic [1:0] up_a;
  logic ep_read;
  logic ep_ready;
  logic [31:0] ep_datain;
  logic [2:0] blocks_avail;
  logic pad_active;
  logic err_underflow;
  int errs = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  localparam logic [31:0] NOP = 32'hF800_0000;

  ok_upstream_blocker #(.NCH(2), .NPC(32), .BLOCK_WORDS(8), .DEPTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .up_v(up_v), .up_d(up_d), .up_a(up_a), .ep_read(ep_read),
    .ep_ready(ep_ready), .ep_datain(ep_datain), .blocks_avail(blocks_avail),
    .pad_active(pad_active), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr_ch(input int ch, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      up_v = 2'(1 << ch);
      up_d = '0;
      up_d[ch*32 +: 32] = base + 32'(i);
      #1;
      chk("wr_up_a", 32'(up_a), 32'(1 << ch));
      cyc();
      exp_q.push_back(base + 32'(i));
    end
    up_v = '0;
  endtask

  task automatic rd(input int n);
    logic [31:0] e;
    ep_read = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc();
      e = exp_q.size() != 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk("rd_data", ep_datain, e);
    end
    ep_read = 1'b0;
  endtask

  initial begin
    int c0, c1, bad;
    logic [1:0] ea;
    reset = 1'b0;
    up_v = '0;
    up_d = '0;
    ep_read = 1'b0;
    cyc();
    cyc();
    chk("rst_up_a", 32'(up_a), 0);
    chk("rst_ep_ready", 32'(ep_ready), 0);
    chk("rst_ep_datain", ep_datain, 0);
    chk("rst_blocks_avail", 32'(blocks_avail), 0);
    chk("rst_pad_active", 32'(pad_active), 0);
    chk("rst_err_underflow", 32'(err_underflow), 0);
    reset = 1'b1;
    cyc();

    // Both channels valid: grants alternate starting from ch0.
    c0 = 0;
    c1 = 0;
    up_v = 2'b11;
    for (int i = 0; i < 8; i++) begin
      up_d = {32'h200 + 32'(c1), 32'h100 + 32'(c0)};
      ea = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk("rr_up_a", 32'(up_a), 32'(ea));
      if (i == 7) chk("rr_avail_before", 32'(blocks_avail), 0);
      cyc();
      if (ea[0]) begin
        exp_q.push_back(32'h100 + 32'(c0));
        c0++;
      end else begin
        exp_q.push_back(32'h200 + 32'(c1));
        c1++;
      end
    end
    up_v = '0;
    chk("rr_avail_t1", 32'(blocks_avail), 1);
    chk("rr_ready_t1", 32'(ep_ready), 0);
    cyc();
    chk("rr_ready_t2", 32'(ep_ready), 1);
    rd(1);
    chk("rr_avail_after_start", 32'(blocks_avail), 0);
    rd(7);

    // Partial block of 3 words.
    wr_ch(0, 32'h300, 3);
`ifdef PC_UP_TIMEOUT_FLUSH_EN
    repeat (14) cyc();
    chk("pad_t15", 32'(pad_active), 0);
    cyc();
    chk("pad_t16", 32'(pad_active), 1);
    repeat (4) cyc();
    chk("pad_t20", 32'(pad_active), 1);
    cyc();
    chk("pad_t21", 32'(pad_active), 0);
    chk("pad_avail", 32'(blocks_avail), 1);
    cyc();
    chk("pad_ready", 32'(ep_ready), 1);
    repeat (5) exp_q.push_back(NOP);
    rd(8);
`else
    bad = 0;
    repeat (1000) begin
      cyc();
      if (ep_ready !== 1'b0 || pad_active !== 1'b0) bad = 1;
    end
    chk("nopad_idle", 32'(bad), 0);
    wr_ch(0, 32'h303, 5);
    chk("nopad_avail", 32'(blocks_avail), 1);
    cyc();
    chk("nopad_ready", 32'(ep_ready), 1);
    rd(8);
`endif

    // Fill the FIFO with the host idle.
    wr_ch(1, 32'h400, 32);
    up_v = 2'b10;
    #1;
    chk("full_up_a", 32'(up_a), 0);
    chk("full_avail", 32'(blocks_avail), 4);
    chk("full_ready", 32'(ep_ready), 1);
    cyc();
    chk("full_up_a_held", 32'(up_a), 0);
    up_v = '0;
    rd(8);
    chk("full_avail_after", 32'(blocks_avail), 3);
    up_v = 2'b10;
    #1;
    chk("full_reopen", 32'(up_a), 32'b10);
    up_v = '0;
    rd(24);

    // Underflow on an empty FIFO.
    ep_read = 1'b1;
    cyc();
    ep_read = 1'b0;
    chk("uf_data", ep_datain, 0);
    chk("uf_err", 32'(err_underflow), 1);
    repeat (3) cyc();
    chk("uf_err_held", 32'(err_underflow), 1);
    wr_ch(0, 32'h500, 8);
    chk("uf_data_held", ep_datain, 0);
    rd(8);
    chk("uf_err_sticky", 32'(err_underflow), 1);

    // Reset in the middle of a block read.
    wr_ch(0, 32'h600, 8);
    rd(4);
    exp_q.delete();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("mid_up_a", 32'(up_a), 0);
    chk("mid_ep_ready", 32'(ep_ready), 0);
    chk("mid_ep_datain", ep_datain, 0);
    chk("mid_blocks_avail", 32'(blocks_avail), 0);
    chk("mid_pad_active", 32'(pad_active), 0);
    chk("mid_err_underflow", 32'(err_underflow), 0);
    wr_ch(0, 32'h700, 8);
    cyc();
    chk("mid_ready", 32'(ep_ready), 1);
    rd(8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
